// File: rtl/regs_2w2r_pkg.sv
// rtl/regs_2w2r_pkg.sv - shared size defaults and depth derivation for regs_2w2r
package regs_2w2r_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 3;
  localparam int CNT_W_DEF  = 16;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  localparam int DEPTH_DEF = depth_of(ADDR_W_DEF);

endpackage

// File: rtl/regs_bypass_rd.sv
// rtl/regs_bypass_rd.sv - one read port with write-first bypass, port 1 wins
module regs_bypass_rd
  import regs_2w2r_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic              valid_i,
  input  logic              byp_en_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] di0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] di1_i,
  output logic [DATA_W-1:0] q_o,
  output logic              v_o
);

  logic hit0, hit1;

  assign hit0 = byp_en_i && we0_i && (addr0_i == rd_addr_i);
  assign hit1 = byp_en_i && we1_i && (addr1_i == rd_addr_i);

  always_comb begin
    q_o = word_i;
    if (hit1) begin
      q_o = di1_i;
    end else if (hit0) begin
      q_o = di0_i;
    end
  end

  assign v_o = valid_i | hit0 | hit1;

endmodule

// File: rtl/regs_2w2r.sv
// rtl/regs_2w2r.sv - 2-write/2-read register file with valid bits, collision flag and write counter; REGS_ZERO_REG_EN makes register 0 a hardwired zero
module regs_2w2r
  import regs_2w2r_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              cr,
  input  logic              WE0,
  input  logic [ADDR_W-1:0] Addr_W0,
  input  logic [DATA_W-1:0] Di0,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] Addr_W1,
  input  logic [DATA_W-1:0] Di1,
  input  logic [ADDR_W-1:0] Addr_A,
  input  logic [ADDR_W-1:0] Addr_B,
  output logic [DATA_W-1:0] QA,
  output logic [DATA_W-1:0] QB,
  output logic              VA,
  output logic              VB,
  output logic              WCOLL,
  output logic [CNT_W-1:0]  WR_CNT
);

  localparam int DEPTH = depth_of(ADDR_W);
`ifdef REGS_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic              wcoll_q, wcoll_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              we0_eff, we1_eff, coll;
  logic [1:0]        n_commit;
  logic [CNT_W:0]    cnt_sum;

  // Writes aimed at a hardwired zero register vanish before any other logic sees them
  assign we0_eff  = WE0 && !(ZERO_REG && (Addr_W0 == '0));
  assign we1_eff  = WE1 && !(ZERO_REG && (Addr_W1 == '0));
  assign coll     = we0_eff && we1_eff && (Addr_W0 == Addr_W1);
  assign n_commit = coll ? 2'd1 : ({1'b0, we0_eff} + {1'b0, we1_eff});
  assign cnt_sum  = {1'b0, cnt_q} + (CNT_W+1)'(n_commit);

  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    if (we0_eff) begin
      mem_d[Addr_W0]   = Di0;
      valid_d[Addr_W0] = 1'b1;
    end
    if (we1_eff) begin
      mem_d[Addr_W1]   = Di1;
      valid_d[Addr_W1] = 1'b1;
    end
    wcoll_d = coll;
    // Increment is at most 2, so any overflow shows up in the carry bit
    cnt_d   = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (cr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      valid_q <= '0;
      wcoll_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
      wcoll_q <= wcoll_d;
      cnt_q   <= cnt_d;
    end
  end

  logic [DATA_W-1:0] word_a, word_b;
  logic              vld_a, vld_b;

  assign word_a = (ZERO_REG && (Addr_A == '0)) ? '0 : mem_q[Addr_A];
  assign word_b = (ZERO_REG && (Addr_B == '0)) ? '0 : mem_q[Addr_B];
  assign vld_a  = valid_q[Addr_A] | (ZERO_REG && (Addr_A == '0));
  assign vld_b  = valid_q[Addr_B] | (ZERO_REG && (Addr_B == '0));

  regs_bypass_rd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_a (
    .rd_addr_i (Addr_A),
    .word_i    (word_a),
    .valid_i   (vld_a),
    .byp_en_i  (!cr),
    .we0_i     (we0_eff),
    .addr0_i   (Addr_W0),
    .di0_i     (Di0),
    .we1_i     (we1_eff),
    .addr1_i   (Addr_W1),
    .di1_i     (Di1),
    .q_o       (QA),
    .v_o       (VA)
  );

  regs_bypass_rd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_b (
    .rd_addr_i (Addr_B),
    .word_i    (word_b),
    .valid_i   (vld_b),
    .byp_en_i  (!cr),
    .we0_i     (we0_eff),
    .addr0_i   (Addr_W0),
    .di0_i     (Di0),
    .we1_i     (we1_eff),
    .addr1_i   (Addr_W1),
    .di1_i     (Di1),
    .q_o       (QB),
    .v_o       (VB)
  );

  assign WCOLL  = wcoll_q;
  assign WR_CNT = cnt_q;

endmodule

// File: tb/tb_regs_2w2r.sv
// tb/tb_regs_2w2r.sv - directed and random checks of regs_2w2r against a behavioural model
module tb_regs_2w2r;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int CW = 4;
  localparam int DEPTH = 8;
  localparam int CMAX = 15;
`ifdef REGS_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          cr;
  logic          WE0, WE1;
  logic [AW-1:0] Addr_W0, Addr_W1, Addr_A, Addr_B;
  logic [DW-1:0] Di0, Di1;
  logic [DW-1:0] QA, QB;
  logic          VA, VB, WCOLL;
  logic [CW-1:0] WR_CNT;

  regs_2w2r #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .cr(cr),
    .WE0(WE0), .Addr_W0(Addr_W0), .Di0(Di0),
    .WE1(WE1), .Addr_W1(Addr_W1), .Di1(Di1),
    .Addr_A(Addr_A), .Addr_B(Addr_B),
    .QA(QA), .QB(QB), .VA(VA), .VB(VB),
    .WCOLL(WCOLL), .WR_CNT(WR_CNT)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] m_mem [DEPTH];
  bit            m_val [DEPTH];
  int            m_cnt;
  bit            m_coll;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // What a reader should see at addr given the current inputs and committed state
  task automatic model_read(input logic [AW-1:0] a, output logic [DW-1:0] q, output bit v);
    if (ZR && a == 0) begin
      q = '0; v = 1'b1;
    end else begin
      q = m_mem[a]; v = m_val[a];
      if (!cr && WE0 && Addr_W0 == a) begin q = Di0; v = 1'b1; end
      if (!cr && WE1 && Addr_W1 == a) begin q = Di1; v = 1'b1; end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_val[i] = 1'b0; end
    m_cnt = 0; m_coll = 1'b0;
  endtask

  task automatic model_commit();
    int            wa[$];
    logic [DW-1:0] wd[$];
    bit            c;
    c = 1'b0;
    if (cr) begin
      model_clear();
      return;
    end
    if (WE0 && !(ZR && Addr_W0 == 0)) begin wa.push_back(int'(Addr_W0)); wd.push_back(Di0); end
    if (WE1 && !(ZR && Addr_W1 == 0)) begin
      if (wa.size() == 1 && wa[0] == int'(Addr_W1)) begin wd[0] = Di1; c = 1'b1; end
      else begin wa.push_back(int'(Addr_W1)); wd.push_back(Di1); end
    end
    foreach (wa[i]) begin m_mem[wa[i]] = wd[i]; m_val[wa[i]] = 1'b1; end
    m_cnt  = (m_cnt + wa.size() > CMAX) ? CMAX : m_cnt + wa.size();
    m_coll = c;
  endtask

  task automatic step(input string tag, input bit c, input bit w0, input int a0, input logic [DW-1:0] d0,
                      input bit w1, input int a1, input logic [DW-1:0] d1, input int ra, input int rb);
    logic [DW-1:0] eq;
    bit            ev;
    cr = c; WE0 = w0; Addr_W0 = AW'(a0); Di0 = d0;
    WE1 = w1; Addr_W1 = AW'(a1); Di1 = d1; Addr_A = AW'(ra); Addr_B = AW'(rb);
    #2;
    model_read(Addr_A, eq, ev);
    chk({tag, ".QA"}, QA, eq);
    chk({tag, ".VA"}, 32'(VA), 32'(ev));
    model_read(Addr_B, eq, ev);
    chk({tag, ".QB"}, QB, eq);
    chk({tag, ".VB"}, 32'(VB), 32'(ev));
    @(posedge clk);
    model_commit();
    #1;
    chk({tag, ".WR_CNT"}, 32'(WR_CNT), 32'(m_cnt));
    chk({tag, ".WCOLL"}, 32'(WCOLL), 32'(m_coll));
  endtask

  initial begin
    cr = 1'b1; WE0 = 0; WE1 = 0; Addr_W0 = 0; Addr_W1 = 0; Di0 = 0; Di1 = 0; Addr_A = 0; Addr_B = 0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();

    step("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step("rd_after_rst", 0, 0, 0, 0, 0, 0, 0, i, 7 - i);

    step("byp_w0", 0, 1, 3, 32'hDEADBEEF, 0, 0, 0, 3, 0);
    step("stored3", 0, 0, 0, 0, 0, 0, 0, 3, 3);

    step("coll", 0, 1, 5, 32'h11, 1, 5, 32'h22, 0, 5);
    step("coll_next", 0, 0, 0, 0, 0, 0, 0, 5, 5);
    step("coll_gone", 0, 0, 0, 0, 0, 0, 0, 5, 3);

    step("dual", 0, 1, 1, 32'hA, 1, 2, 32'hB, 1, 2);
    step("dual_next", 0, 0, 0, 0, 0, 0, 0, 1, 2);

    step("zero_w1", 0, 0, 0, 0, 1, 0, 32'h55, 0, 0);
    step("zero_next", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    step("rst_coll", 1, 1, 4, 32'h77, 1, 4, 32'h88, 4, 4);
    step("after_rst_coll", 0, 0, 0, 0, 0, 0, 0, 4, 4);

    for (int i = 0; i < 20; i++) step("sat", 0, 1, (i % 7) + 1, 32'(i), 0, 0, 0, (i % 7) + 1, 6);
    step("sat_dual", 0, 1, 2, 32'h1, 1, 3, 32'h2, 2, 3);

    for (int i = 0; i < 300; i++) begin
      int a0, a1, ra, rb;
      a0 = $urandom_range(0, DEPTH - 1);
      a1 = ($urandom_range(0, 3) == 0) ? a0 : $urandom_range(0, DEPTH - 1);
      ra = ($urandom_range(0, 2) == 0) ? a0 : $urandom_range(0, DEPTH - 1);
      rb = ($urandom_range(0, 2) == 0) ? a1 : $urandom_range(0, DEPTH - 1);
      step("rand", ($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1, a0, $urandom,
           $urandom_range(0, 1) == 1, a1, $urandom, ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
